// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control unit for a multicycle ARM-subset processor.
//               Sequences the shared ALU, memory port and register file
//               through fetch/decode/execute/memory/writeback, drives all
//               datapath selects, and holds the NZCV condition flags.
//               Every architectural write enable is gated by the condition
//               code of the instruction in the instruction register.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               Cond/Op/Funct/Rd    - instruction register fields
//               ALUFlags            - {N,Z,C,V} from the ALU this cycle
//               PCWrite/MemWrite/RegWrite/IRWrite - write enables
//               AdrSrc/ALUSrcA/ResultSrc/ALUSrcB/ImmSrc/RegSrc/ALUControl
//                                   - datapath selects
//               Flags               - registered NZCV
//               State               - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [3:0]         Flags,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] C_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] C_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] C_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] C_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] C_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] C_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] C_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] C_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] C_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] C_BRANCH   = STATE_W'(9);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         flags_q, flags_d;

  // While reset is held, outputs present FETCH so the datapath sees a
  // benign, well-defined select set; write enables are masked separately.
  logic [STATE_W-1:0] w_cur_state;
  assign w_cur_state = reset ? C_FETCH : state_q;

  // --------------------------------------------------------------------------
  // State register and flag register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= C_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = C_FETCH;
    case (state_q)
      C_FETCH:  state_d = C_DECODE;
      C_DECODE: begin
        case (Op)
          2'b01:   state_d = C_MEMADR;
          2'b00:   state_d = Funct[5] ? C_EXECUTEI : C_EXECUTER;
          2'b10:   state_d = C_BRANCH;
          default: state_d = C_FETCH;
        endcase
      end
      C_MEMADR:   state_d = Funct[0] ? C_MEMREAD : C_MEMWRITE;
      C_MEMREAD:  state_d = C_MEMWB;
      C_MEMWB:    state_d = C_FETCH;
      C_MEMWRITE: state_d = C_FETCH;
      C_EXECUTER: state_d = C_ALUWB;
      C_EXECUTEI: state_d = C_ALUWB;
      C_ALUWB:    state_d = C_FETCH;
      C_BRANCH:   state_d = C_FETCH;
      default:    state_d = C_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-state control outputs (ungated)
  // --------------------------------------------------------------------------
  logic w_next_pc, w_branch, w_reg_w, w_mem_w, w_alu_op, w_ir_write;

  always_comb begin
    w_next_pc  = 1'b0;
    w_branch   = 1'b0;
    w_reg_w    = 1'b0;
    w_mem_w    = 1'b0;
    w_alu_op   = 1'b0;
    w_ir_write = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (w_cur_state)
      C_FETCH: begin
        w_ir_write = 1'b1;
        w_next_pc  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      C_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      C_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      C_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      C_MEMWB: begin
        ResultSrc = 2'b01;
        w_reg_w   = 1'b1;
      end
      C_MEMWRITE: begin
        AdrSrc  = 1'b1;
        w_mem_w = 1'b1;
      end
      C_EXECUTER: begin
        w_alu_op = 1'b1;
      end
      C_EXECUTEI: begin
        ALUSrcB  = 2'b01;
        w_alu_op = 1'b1;
      end
      C_ALUWB: begin
        w_reg_w = 1'b1;
      end
      C_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU decoder
  // --------------------------------------------------------------------------
  logic [1:0] w_flag_w;
  logic [3:0] w_cmd;
  assign w_cmd = Funct[4:1];

  always_comb begin
    ALUControl = 2'b00;
    w_flag_w   = 2'b00;
    if (w_alu_op) begin
      case (w_cmd)
        4'b0100: begin ALUControl = 2'b00; w_flag_w = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; w_flag_w = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; w_flag_w = {Funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; w_flag_w = {Funct[0], 1'b0};     end
        default: begin ALUControl = 2'b00; w_flag_w = 2'b00;                end
      endcase
    end
  end

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

  // --------------------------------------------------------------------------
  // Condition evaluation against the registered flags
  // --------------------------------------------------------------------------
  logic w_n, w_z, w_c, w_v, w_cond_ex;
  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Gated write enables
  // --------------------------------------------------------------------------
  logic w_pcs;
  assign w_pcs    = w_branch | (w_reg_w & (Rd == 4'd15));
  assign PCWrite  = ~reset & (w_next_pc | (w_pcs & w_cond_ex));
  assign RegWrite = ~reset & w_reg_w & w_cond_ex;
  assign MemWrite = ~reset & w_mem_w & w_cond_ex;
  assign IRWrite  = ~reset & w_ir_write;

  // Flags are only written by a data-processing execute whose condition holds.
  logic w_flag_upd;
  assign w_flag_upd = ((state_q == C_EXECUTER) || (state_q == C_EXECUTEI)) && w_cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (w_flag_upd) begin
      if (w_flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (w_flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  assign Flags = flags_q;
  assign State = w_cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. Each issued
//               instruction pushes its expected per-cycle output records;
//               a monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int STATE_W = 4;

  // Step codes of an instruction's path
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                 P_ALUWB = 8, P_BRANCH = 9;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adr;
    logic       srca;
    logic [1:0] res;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic [1:0] aluc;
    logic [3:0] flags;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;

  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags;
  logic [STATE_W-1:0] State;

  multicycle_controller #(.STATE_W(STATE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (instr[31:28]),
    .Op         (instr[27:26]),
    .Funct      (instr[25:20]),
    .Rd         (instr[15:12]),
    .ALUFlags   (alu_flags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .State      (State)
  );

  obs_t        exp_q[$];
  logic [31:0] tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  mf = 4'b0000;   // reference model of the NZCV register

  // --------------------------------------------------------------------------
  // Reference model helpers
  // --------------------------------------------------------------------------
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int path_len(input logic [31:0] ins);
    case (ins[27:26])
      2'b01:   return ins[20] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic obs_t base_rec(input logic [1:0] op, input logic [3:0] f);
    obs_t r;
    r        = '0;
    r.imm    = op;
    r.regsrc = {op == 2'b01, op == 2'b10};
    r.flags  = f;
    return r;
  endfunction

  // Outputs expected while reset is held: FETCH selects, no write enables.
  function automatic obs_t reset_rec(input logic [1:0] op, input logic [3:0] f);
    obs_t r;
    r      = base_rec(op, f);
    r.srca = 1'b1;
    r.srcb = 2'b10;
    r.res  = 2'b10;
    return r;
  endfunction

  // Builds the expected records of one instruction, optionally abandoned by
  // a one-cycle reset at step abort_at, then drives it and waits it out.
  task automatic issue(input logic [31:0] ins, input logic [3:0] af, input int abort_at);
    int         ph[$];
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] cmd;
    logic       ce, wb_pc;
    logic       k_add, k_sub, k_and, k_orr;
    logic [1:0] aluc;
    obs_t       r;
    int         ncyc;

    op  = ins[27:26];
    fn  = ins[25:20];
    cmd = fn[4:1];
    k_add = (cmd == 4'b0100);
    k_sub = (cmd == 4'b0010);
    k_and = (cmd == 4'b0000);
    k_orr = (cmd == 4'b1100);
    aluc  = k_sub ? 2'b01 : k_and ? 2'b10 : k_orr ? 2'b11 : 2'b00;

    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (op)
      2'b01: begin
        ph.push_back(P_MEMADR);
        if (fn[0]) begin ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
        else       ph.push_back(P_MEMWRITE);
      end
      2'b00: begin
        ph.push_back(fn[5] ? P_EXECI : P_EXECR);
        ph.push_back(P_ALUWB);
      end
      2'b10:   ph.push_back(P_BRANCH);
      default: ;
    endcase

    ncyc = ph.size();
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort_at) begin
        exp_q.push_back(reset_rec(op, mf));
        tag_q.push_back(ins);
        mf   = 4'b0000;
        ncyc = i + 1;
        break;
      end
      ce    = cond_ok(ins[31:28], mf);
      wb_pc = (ins[15:12] == 4'd15) && ce;
      r     = base_rec(op, mf);
      r.st  = 4'(ph[i]);
      case (ph[i])
        P_FETCH:    begin r.irw = 1; r.pcw = 1; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; end
        P_DECODE:   begin r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; end
        P_MEMADR:   begin r.srcb = 2'b01; end
        P_MEMREAD:  begin r.adr = 1; end
        P_MEMWB:    begin r.res = 2'b01; r.regw = ce; r.pcw = wb_pc; end
        P_MEMWRITE: begin r.adr = 1; r.memw = ce; end
        P_EXECR, P_EXECI: begin
          r.srcb = (ph[i] == P_EXECI) ? 2'b01 : 2'b00;
          r.aluc = aluc;
          if (ce && fn[0] && (k_add || k_sub || k_and || k_orr)) mf[3:2] = af[3:2];
          if (ce && fn[0] && (k_add || k_sub))                   mf[1:0] = af[1:0];
        end
        P_ALUWB:    begin r.regw = ce; r.pcw = wb_pc; end
        P_BRANCH:   begin r.srcb = 2'b01; r.res = 2'b10; r.pcw = ce; end
        default: ;
      endcase
      exp_q.push_back(r);
      tag_q.push_back(ins);
    end

    instr     = ins;
    alu_flags = af;
    for (int i = 0; i < ncyc; i++) begin
      if (i == abort_at) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one comparison per cycle while expectations are pending
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    obs_t        act, ex;
    logic [31:0] tg;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      tg  = tag_q.pop_front();
      act = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
             ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags};
      n_checks++;
      if (act === ex) n_pass++;
      else $display("FAIL outputs instr=%h t=%0t got st=%0d pcw=%b mw=%b rw=%b irw=%b adr=%b sa=%b res=%b sb=%b imm=%b rs=%b aluc=%b fl=%b required st=%0d pcw=%b mw=%b rw=%b irw=%b adr=%b sa=%b res=%b sb=%b imm=%b rs=%b aluc=%b fl=%b",
                    tg, $time,
                    act.st, act.pcw, act.memw, act.regw, act.irw, act.adr, act.srca,
                    act.res, act.srcb, act.imm, act.regsrc, act.aluc, act.flags,
                    ex.st, ex.pcw, ex.memw, ex.regw, ex.irw, ex.adr, ex.srca,
                    ex.res, ex.srcb, ex.imm, ex.regsrc, ex.aluc, ex.flags);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] ins;
    int          ab;

    reset     = 1'b1;
    instr     = 32'h0;
    alu_flags = 4'h0;
    @(posedge clk);
    #1;
    // Second reset cycle: state FETCH, flags cleared, enables masked.
    exp_q.push_back(reset_rec(2'b00, 4'b0000));
    tag_q.push_back(32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed sequence
    issue(32'hE2821005, 4'b1111, -1);   // ADD R1,R2,#5 (no S: flags unchanged)
    issue(32'hE5903008, 4'b1010, -1);   // LDR R3,[R0,#8]
    issue(32'hE5803008, 4'b0101, -1);   // STR R3,[R0,#8]
    issue(32'hE2500001, 4'b0100, -1);   // SUBS -> Z set
    issue(32'h0A000003, 4'b0000, -1);   // BEQ taken
    issue(32'hE2500001, 4'b0100, -1);
    issue(32'h1A000003, 4'b0000, -1);   // BNE not taken
    issue(32'hE5903008, 4'b0000,  3);   // LDR abandoned in MEMREAD
    issue(32'hE2500001, 4'b1011, -1);   // SUBS: all four flags
    issue(32'hE081F002, 4'b0000, -1);   // ADD PC,R1,R2
    issue(32'hF081F002, 4'b0000, -1);   // never-condition variant
    issue(32'hE3500000, 4'b0100, -1);   // unsupported cmd with S: no flag write
    issue(32'hE2800000, 4'b1010, 2);    // abort during EXECUTEI

    // Randomized instructions
    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
      ab = -1;
      if ($urandom_range(0, 15) == 0) ab = $urandom_range(0, path_len(ins) - 1);
      issue(ins, 4'($urandom), ab);
    end

    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending records, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
